// File: rtl/pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pattern_scan_ctrl
// Description : Sequencer for the serial string recognizer. Captures a
//               WORD_W-bit word and a PAT_W-bit pattern on an accepted start.
//               It then shifts the word out MSB-first, one bit per clock, on
//               w_out. It flags every overlapping occurrence of the pattern
//               on hit and keeps a running match count.
// Ports       : clk          - single clock, all state updates on posedge
//               reset        - synchronous reset, active-low
//               start        - scan request, sampled only in IDLE
//               abort        - cancel request, sampled only in SHIFT
//               data_in      - word to scan, captured on accepted start
//               pattern      - pattern, captured on accepted start (MSB first)
//               busy         - high in SHIFT and DONE
//               w_out        - current serial bit (0 outside SHIFT)
//               hit          - this cycle's w_out completes a pattern match
//               done         - one-cycle pulse after the last bit
//               match_count  - matches in the current/last scan
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_scan_ctrl #(
    parameter int WORD_W = 16,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] data_in,
    input  logic [PAT_W-1:0]  pattern,
    output logic              busy,
    output logic              w_out,
    output logic              hit,
    output logic              done,
    output logic [CNT_W-1:0]  match_count
);

    localparam int c_IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX      = c_IDX_W'(WORD_W - 1);
    localparam logic [c_IDX_W-1:0] c_FIRST_HIT_IDX = c_IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        c_ST_IDLE  = 2'd0,
        c_ST_SHIFT = 2'd1,
        c_ST_DONE  = 2'd2
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [WORD_W-1:0]   r_shift_q, w_shift_d;
    logic [PAT_W-1:0]    r_pat_q,   w_pat_d;
    logic [PAT_W-2:0]    r_hist_q,  w_hist_d;   // previous PAT_W-1 serial bits
    logic [c_IDX_W-1:0]  r_idx_q,   w_idx_d;    // index of the bit on w_out
    logic [CNT_W-1:0]    r_cnt_q,   w_cnt_d;
    logic                r_busy_q,  w_busy_d;
    logic                r_done_q,  w_done_d;

    logic                w_in_shift;
    logic [PAT_W-1:0]    w_window;

    // Serial view: the MSB of the shift register is the current bit. The
    // comparison window is the history plus that bit. The index guard keeps
    // the cleared history from pretending to be real pre-scan bits.
    assign w_in_shift = (r_state_q == c_ST_SHIFT);
    assign w_out      = w_in_shift & r_shift_q[WORD_W-1];
    assign w_window   = {r_hist_q, w_out};
    assign hit        = w_in_shift && (r_idx_q >= c_FIRST_HIT_IDX) && (w_window == r_pat_q);

    assign busy        = r_busy_q;
    assign done        = r_done_q;
    assign match_count = r_cnt_q;

    always_comb begin
        w_state_d = r_state_q;
        w_shift_d = r_shift_q;
        w_pat_d   = r_pat_q;
        w_hist_d  = r_hist_q;
        w_idx_d   = r_idx_q;
        w_cnt_d   = r_cnt_q;
        w_busy_d  = r_busy_q;
        w_done_d  = 1'b0;

        case (r_state_q)
            c_ST_IDLE: begin
                // Any abort arriving with start is ignored here.
                if (start) begin
                    w_state_d = c_ST_SHIFT;
                    w_shift_d = data_in;
                    w_pat_d   = pattern;
                    w_hist_d  = '0;
                    w_idx_d   = '0;
                    w_cnt_d   = '0;
                    w_busy_d  = 1'b1;
                end
            end

            c_ST_SHIFT: begin
                w_shift_d = r_shift_q << 1;
                w_hist_d  = w_window[PAT_W-2:0];   // history survives hits, so matches overlap
                w_idx_d   = r_idx_q + c_IDX_W'(1);
                // A hit in the abort cycle still counts.
                if (hit) begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
                if (abort) begin
                    w_state_d = c_ST_IDLE;
                    w_busy_d  = 1'b0;
                end else if (r_idx_q == c_LAST_IDX) begin
                    w_state_d = c_ST_DONE;
                    w_done_d  = 1'b1;
                end
            end

            c_ST_DONE: begin
                w_state_d = c_ST_IDLE;
                w_busy_d  = 1'b0;
            end

            default: begin
                w_state_d = c_ST_IDLE;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q <= c_ST_IDLE;
            r_shift_q <= '0;
            r_pat_q   <= '0;
            r_hist_q  <= '0;
            r_idx_q   <= '0;
            r_cnt_q   <= '0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_shift_q <= w_shift_d;
            r_pat_q   <= w_pat_d;
            r_hist_q  <= w_hist_d;
            r_idx_q   <= w_idx_d;
            r_cnt_q   <= w_cnt_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_scan_ctrl
// Description : Self-checking bench for pattern_scan_ctrl. Directed scenarios
//               are followed by randomized scans. Each scan is checked against
//               a window-comparison reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_scan_ctrl;

    localparam int WORD_W = 16;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [WORD_W-1:0] data_in = '0;
    logic [PAT_W-1:0]  pattern = '0;
    logic              busy;
    logic              w_out;
    logic              hit;
    logic              done;
    logic [CNT_W-1:0]  match_count;

    int n_cmp = 0;
    int n_err = 0;

    pattern_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .data_in     (data_in),
        .pattern     (pattern),
        .busy        (busy),
        .w_out       (w_out),
        .hit         (hit),
        .done        (done),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: bit i is data[WORD_W-1-i]. A match ends at i when the PAT_W
    // bits i-PAT_W+1..i, read MSB-first, equal the pattern.
    function automatic logic ref_bit(input logic [WORD_W-1:0] d, input int i);
        return d[WORD_W-1-i];
    endfunction

    function automatic logic ref_hit(input logic [WORD_W-1:0] d, input logic [PAT_W-1:0] p, input int i);
        logic [WORD_W-1:0] sh;
        if (i < PAT_W - 1) return 1'b0;
        sh = d >> (WORD_W - 1 - i);
        return sh[PAT_W-1:0] == p;
    endfunction

    task automatic idle_check(input string tag, input logic [CNT_W-1:0] cnt);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_wout"},  32'(w_out), 32'd0);
        chk({tag, "_hit"},   32'(hit),   32'd0);
        chk({tag, "_count"}, 32'(match_count), 32'(cnt));
    endtask

    // One full scan. abort_i / rst_i / restart_i select a bit index at which to
    // abort, assert reset, or pulse a (to-be-ignored) start; -1 disables.
    // with_abort puts abort high together with the accepted start.
    // Returns the count the model expects at the end.
    task automatic scan(input string tag, input logic [WORD_W-1:0] d, input logic [PAT_W-1:0] p,
                        input int abort_i, input int rst_i, input int restart_i,
                        input bit with_abort, output int cnt);
        cnt = 0;
        @(negedge clk);
        data_in = d;
        pattern = p;
        start   = 1'b1;
        abort   = with_abort;
        @(negedge clk);
        start   = 1'b0;
        abort   = 1'b0;
        data_in = WORD_W'($urandom);     // the DUT must work from its latched copies
        pattern = PAT_W'($urandom);
        for (int i = 0; i < WORD_W; i++) begin
            chk({tag, "_busy"},  32'(busy),  32'd1);
            chk({tag, "_done"},  32'(done),  32'd0);
            chk({tag, "_wout"},  32'(w_out), 32'(ref_bit(d, i)));
            chk({tag, "_hit"},   32'(hit),   32'(ref_hit(d, p, i)));
            chk({tag, "_count"}, 32'(match_count), 32'(cnt));
            if (ref_hit(d, p, i)) cnt++;
            if (i == abort_i)   abort = 1'b1;
            if (i == rst_i)     reset = 1'b0;
            if (i == restart_i) begin
                start   = 1'b1;
                data_in = '1;
                pattern = '1;
            end
            @(negedge clk);
            abort = 1'b0;
            reset = 1'b1;
            start = 1'b0;
            if (i == abort_i) begin
                idle_check({tag, "_abort"}, CNT_W'(cnt));
                return;
            end
            if (i == rst_i) begin
                cnt = 0;
                idle_check({tag, "_reset"}, '0);
                return;
            end
        end
        chk({tag, "_done_pulse"}, 32'(done),  32'd1);
        chk({tag, "_done_busy"},  32'(busy),  32'd1);
        chk({tag, "_done_wout"},  32'(w_out), 32'd0);
        chk({tag, "_done_hit"},   32'(hit),   32'd0);
        chk({tag, "_done_count"}, 32'(match_count), 32'(cnt));
        @(negedge clk);
        idle_check({tag, "_post"}, CNT_W'(cnt));
    endtask

    initial begin
        int cnt;
        logic [WORD_W-1:0] d;
        logic [PAT_W-1:0]  p;
        int ab;
        int pos;

        // Reset state, with start held high to show reset dominates.
        reset = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        idle_check("reset", '0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        idle_check("reset_rel", '0);

        // Directed scenarios.
        scan("t1", 16'hDB6D, 4'b1101, -1, -1, -1, 1'b0, cnt);
        chk("t1_final", 32'(match_count), 32'd5);
        scan("t2", 16'h0000, 4'b0000, -1, -1, -1, 1'b0, cnt);
        chk("t2_final", 32'(match_count), 32'd13);
        scan("t3", 16'h0000, 4'b1101, -1, -1, -1, 1'b0, cnt);
        chk("t3_final", 32'(match_count), 32'd0);
        scan("t4", 16'hDB6D, 4'b1101, -1, -1, 5, 1'b0, cnt);
        chk("t4_final", 32'(match_count), 32'd5);
        scan("t5", 16'hDB6D, 4'b1101, 7, -1, -1, 1'b0, cnt);
        chk("t5_final", 32'(match_count), 32'd2);
        scan("t6", 16'hDB6D, 4'b1101, -1, 10, -1, 1'b0, cnt);
        chk("t6_final", 32'(match_count), 32'd0);
        scan("t6r", 16'hDB6D, 4'b1101, -1, -1, -1, 1'b0, cnt);
        chk("t6r_final", 32'(match_count), 32'd5);
        scan("sa", 16'hDB6D, 4'b1101, -1, -1, -1, 1'b1, cnt);
        chk("sa_final", 32'(match_count), 32'd5);
        scan("ab15", 16'hFFFF, 4'b1111, 15, -1, -1, 1'b0, cnt);
        chk("ab15_final", 32'(match_count), 32'd13);

        // Held count across several idle cycles.
        repeat (3) @(negedge clk);
        idle_check("hold", 5'd13);

        // Randomized scans; the pattern is often lifted from the word itself
        // so that hits are common.
        for (int n = 0; n < 40; n++) begin
            d = WORD_W'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                pos = $urandom_range(0, WORD_W - PAT_W);
                p   = PAT_W'(d >> pos);
            end else begin
                p = PAT_W'($urandom);
            end
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WORD_W - 1)) : -1;
            scan("rnd", d, p, ab, -1, -1, 1'($urandom_range(0, 1)), cnt);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            idle_check("rnd_gap", CNT_W'(cnt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
